dram_port_arbiter: RTL and testbench

DRAM_PORT_ARBITER -- requirements
Module: dram_port_arbiter

---
 rtl/dram_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_dram_port_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_port_arbiter.sv
// Shares one DRAM port between the fetch and MEM stages.
// One access in flight at a time; ties alternate between requesters.
module dram_port_arbiter #(
  parameter int DRAM_LATENCY = 1,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [2:0]        mem_rd_ctrl,
  input  logic [1:0]        mem_wr_ctrl,
  input  logic [ADDR_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [2:0]        dram_rd_ctrl,
  output logic [1:0]        dram_wr_ctrl,
  output logic [ADDR_W-1:0] dram_wdata,
  input  logic [ADDR_W-1:0] dram_rdata,
  output logic [ADDR_W-1:0] if_rdata,
  output logic [ADDR_W-1:0] mem_rdata,
  output logic              if_valid,
  output logic              mem_valid,
  output logic              if_stall,
  output logic              mem_stall
);

  localparam logic [2:0] LAT = 3'(DRAM_LATENCY);
  localparam logic [2:0] FETCH_RD = 3'b101;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic              kill, kill_nxt;
  logic              last_if, last_if_nxt;
  logic [ADDR_W-1:0] addr_q, wdata_q;
  logic [ADDR_W-1:0] if_rdata_q, mem_rdata_q;
  logic [2:0]        rd_q;
  logic              want_if, grant_if, grant_mem;
  logic              done, mem_cap;

  assign want_if = if_req & ~if_flush;
  assign done = (cnt == 3'd1);

  // No grant while reset is held so the DRAM bus stays quiet.
  assign grant_if = (state == IDLE) & ~reset & want_if
                  & (~mem_req | ~last_if);
  assign grant_mem = (state == IDLE) & ~reset & mem_req & ~grant_if;

  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    kill_nxt = kill;
    last_if_nxt = last_if;
    dram_addr = '0;
    dram_rd_ctrl = '0;
    dram_wr_ctrl = '0;
    dram_wdata = '0;
    if_valid = 1'b0;
    mem_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_if) begin
          dram_addr = if_addr;
          dram_rd_ctrl = FETCH_RD;
          state_nxt = BUSY_IF;
          cnt_nxt = LAT;
          kill_nxt = 1'b0;
          last_if_nxt = 1'b1;
        end else if (grant_mem) begin
          dram_addr = mem_addr;
          dram_rd_ctrl = mem_rd_ctrl;
          dram_wr_ctrl = mem_wr_ctrl;
          dram_wdata = mem_wdata;
          state_nxt = BUSY_MEM;
          cnt_nxt = LAT;
          last_if_nxt = 1'b0;
        end
      end
      BUSY_IF: begin
        dram_addr = addr_q;
        dram_rd_ctrl = rd_q;
        dram_wdata = wdata_q;
        cnt_nxt = cnt - 3'd1;
        if (if_flush) kill_nxt = 1'b1;
        // A flush in the final cycle must also suppress the pulse.
        if_valid = done & ~kill & ~if_flush;
        if (done) begin
          state_nxt = IDLE;
          kill_nxt = 1'b0;
        end
      end
      BUSY_MEM: begin
        dram_addr = addr_q;
        dram_rd_ctrl = rd_q;
        dram_wdata = wdata_q;
        cnt_nxt = cnt - 3'd1;
        mem_valid = done;
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      kill <= 1'b0;
      last_if <= 1'b1;
      addr_q <= '0;
      rd_q <= '0;
      wdata_q <= '0;
      if_rdata_q <= '0;
      mem_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      kill <= kill_nxt;
      last_if <= last_if_nxt;
      if (state == IDLE) begin
        addr_q <= dram_addr;
        rd_q <= dram_rd_ctrl;
        wdata_q <= dram_wdata;
      end
      if (if_valid) if_rdata_q <= dram_rdata;
      if (mem_cap) mem_rdata_q <= dram_rdata;
    end
  end

  // Store-only accesses leave the load data untouched.
  assign mem_cap = mem_valid & (rd_q != 3'b000);

  assign if_rdata = if_valid ? dram_rdata : if_rdata_q;
  assign mem_rdata = mem_cap ? dram_rdata : mem_rdata_q;

  assign if_stall = if_req & ~if_valid;
  assign mem_stall = mem_req & ~mem_valid;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: LAT=1 and LAT=3 copies share stimulus
// and are checked against a timestamp-based model every cycle.
module tb_dram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, mem_req;
  logic [63:0] if_addr, mem_addr, mem_wdata, dram_rdata;
  logic [2:0]  mem_rd_ctrl;
  logic [1:0]  mem_wr_ctrl;

  logic [63:0] d_addr[2], d_wd[2], ifrd[2], memrd[2];
  logic [2:0]  d_rd[2];
  logic [1:0]  d_wr[2];
  logic        ifv[2], memv[2], ifs[2], mems[2];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dram_port_arbiter #(
      .DRAM_LATENCY(g == 0 ? 1 : 3),
      .ADDR_W(64)
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .if_req(if_req),
      .if_addr(if_addr),
      .if_flush(if_flush),
      .mem_req(mem_req),
      .mem_addr(mem_addr),
      .mem_rd_ctrl(mem_rd_ctrl),
      .mem_wr_ctrl(mem_wr_ctrl),
      .mem_wdata(mem_wdata),
      .dram_addr(d_addr[g]),
      .dram_rd_ctrl(d_rd[g]),
      .dram_wr_ctrl(d_wr[g]),
      .dram_wdata(d_wd[g]),
      .dram_rdata(dram_rdata),
      .if_rdata(ifrd[g]),
      .mem_rdata(memrd[g]),
      .if_valid(ifv[g]),
      .mem_valid(memv[g]),
      .if_stall(ifs[g]),
      .mem_stall(mems[g])
    );
  end

  typedef struct {
    logic        act;
    logic        own_if;
    logic        kill;
    logic        last_if;
    int          issue;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] ifr;
    logic [63:0] memr;
    logic [2:0]  rd;
  } mst_t;

  mst_t m[2];
  mst_t n[2];

  typedef struct packed {
    logic       ifr;
    logic       ifl;
    logic       mr;
    logic [2:0] mrd;
    logic [1:0] mwr;
    logic [2:0] e_rd;
    logic       e_ifv;
    logic       e_memv;
    logic       e_ifs;
    logic       e_mems;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic mst_t mrst();
    mst_t r;
    r.act = 1'b0;
    r.own_if = 1'b0;
    r.kill = 1'b0;
    r.last_if = 1'b1;
    r.issue = 0;
    r.addr = '0;
    r.wd = '0;
    r.ifr = '0;
    r.memr = '0;
    r.rd = '0;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) m[i] = mrst();
  endtask

  // Expected outputs for this cycle; next model state goes into n[].
  task automatic model_check();
    for (int i = 0; i < 2; i++) begin
      int          lat;
      mst_t        s;
      logic [63:0] ea, ew, eir, emr;
      logic [2:0]  er;
      logic [1:0]  ewr;
      logic        eiv, emv, wi, gi, gm, fin;
      lat = (i == 0) ? 1 : 3;
      s = m[i];
      ea = '0; ew = '0; er = '0; ewr = '0;
      eiv = 1'b0; emv = 1'b0;
      eir = m[i].ifr; emr = m[i].memr;
      if (reset) begin
        s = mrst();
        eir = '0;
        emr = '0;
      end else if (m[i].act) begin
        fin = (cyc - m[i].issue) == lat;
        ea = m[i].addr;
        er = m[i].rd;
        ew = m[i].wd;
        if (m[i].own_if) begin
          eiv = fin && !m[i].kill && !if_flush;
          s.kill = m[i].kill || if_flush;
        end else begin
          emv = fin;
        end
        if (eiv) eir = dram_rdata;
        if (emv && m[i].rd != 3'b000) emr = dram_rdata;
        s.ifr = eir;
        s.memr = emr;
        if (fin) s.act = 1'b0;
      end else begin
        wi = if_req && !if_flush;
        if (wi && mem_req) gi = !m[i].last_if;
        else gi = wi;
        gm = mem_req && !gi;
        if (gi) begin
          ea = if_addr;
          er = 3'b101;
          s.act = 1'b1;
          s.own_if = 1'b1;
          s.last_if = 1'b1;
        end else if (gm) begin
          ea = mem_addr;
          er = mem_rd_ctrl;
          ewr = mem_wr_ctrl;
          ew = mem_wdata;
          s.act = 1'b1;
          s.own_if = 1'b0;
          s.last_if = 1'b0;
        end
        s.kill = 1'b0;
        s.issue = cyc;
        s.addr = ea;
        s.rd = er;
        s.wd = ew;
      end
      n[i] = s;
      chk($sformatf("m%0d.c%0d.dram_addr", i, cyc), d_addr[i], ea);
      chk($sformatf("m%0d.c%0d.dram_rd", i, cyc), 64'(d_rd[i]), 64'(er));
      chk($sformatf("m%0d.c%0d.dram_wr", i, cyc), 64'(d_wr[i]), 64'(ewr));
      chk($sformatf("m%0d.c%0d.dram_wdata", i, cyc), d_wd[i], ew);
      chk($sformatf("m%0d.c%0d.if_valid", i, cyc), 64'(ifv[i]), 64'(eiv));
      chk($sformatf("m%0d.c%0d.mem_valid", i, cyc), 64'(memv[i]), 64'(emv));
      chk($sformatf("m%0d.c%0d.if_rdata", i, cyc), ifrd[i], eir);
      chk($sformatf("m%0d.c%0d.mem_rdata", i, cyc), memrd[i], emr);
      chk($sformatf("m%0d.c%0d.if_stall", i, cyc), 64'(ifs[i]),
          64'(if_req & ~eiv));
      chk($sformatf("m%0d.c%0d.mem_stall", i, cyc), 64'(mems[i]),
          64'(mem_req & ~emv));
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    m[0] = n[0];
    m[1] = n[1];
    cyc++;
    #1;
    dram_rdata = {$urandom, $urandom};
  endtask

  task automatic idle(int cycles);
    if_req = 1'b0;
    if_flush = 1'b0;
    mem_req = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      settle();
      adv();
    end
  endtask

  initial begin
    logic [63:0] keep;
    int          nwr;
    vec_t        v;

    tbl[0]  = {1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = {1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = {1'b1, 1'b0, 1'b1, 3'b010, 2'b00, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3]  = {1'b1, 1'b0, 1'b1, 3'b010, 2'b00, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = {1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = {1'b1, 1'b0, 1'b1, 3'b010, 2'b00, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6]  = {1'b1, 1'b0, 1'b1, 3'b010, 2'b00, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7]  = {1'b1, 1'b0, 1'b1, 3'b010, 2'b00, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = {1'b1, 1'b0, 1'b1, 3'b010, 2'b00, 3'b101, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = {1'b1, 1'b0, 1'b1, 3'b010, 2'b00, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = {1'b1, 1'b0, 1'b1, 3'b010, 2'b00, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[11] = {1'b1, 1'b0, 1'b1, 3'b010, 2'b00, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[12] = {1'b1, 1'b1, 1'b1, 3'b010, 2'b00, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[13] = {1'b1, 1'b0, 1'b1, 3'b010, 2'b00, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[14] = {1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};

    model_reset();
    reset = 1'b1;
    if_req = 1'b0;
    if_flush = 1'b0;
    mem_req = 1'b0;
    if_addr = '0;
    mem_addr = '0;
    mem_wdata = '0;
    mem_rd_ctrl = '0;
    mem_wr_ctrl = '0;
    dram_rdata = {$urandom, $urandom};

    // reset state
    settle();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d.dram_rd", i), 64'(d_rd[i]), 64'd0);
      chk($sformatf("rst%0d.dram_addr", i), d_addr[i], 64'd0);
      chk($sformatf("rst%0d.if_valid", i), 64'(ifv[i]), 64'd0);
      chk($sformatf("rst%0d.mem_rdata", i), memrd[i], 64'd0);
    end
    adv();
    reset = 1'b0;

    // table: fetch-only, tie alternation, flush blocking IF in IDLE (LAT=1)
    for (int k = 0; k < 15; k++) begin
      v = tbl[k];
      if_req = v.ifr;
      if_flush = v.ifl;
      mem_req = v.mr;
      mem_rd_ctrl = v.mrd;
      mem_wr_ctrl = v.mwr;
      if_addr = 64'h8000_0000;
      mem_addr = 64'h1000;
      mem_wdata = '0;
      settle();
      chk($sformatf("tbl%0d.dram_rd", k), 64'(d_rd[0]), 64'(v.e_rd));
      chk($sformatf("tbl%0d.if_valid", k), 64'(ifv[0]), 64'(v.e_ifv));
      chk($sformatf("tbl%0d.mem_valid", k), 64'(memv[0]), 64'(v.e_memv));
      chk($sformatf("tbl%0d.if_stall", k), 64'(ifs[0]), 64'(v.e_ifs));
      chk($sformatf("tbl%0d.mem_stall", k), 64'(mems[0]), 64'(v.e_mems));
      if (v.e_rd != 3'b000)
        chk($sformatf("tbl%0d.dram_addr", k), d_addr[0],
            (v.e_rd == 3'b101) ? if_addr : mem_addr);
      if (v.e_ifv)
        chk($sformatf("tbl%0d.if_rdata", k), ifrd[0], dram_rdata);
      adv();
    end

    // LAT=3 store-only access
    idle(6);
    keep = m[1].memr;
    nwr = 0;
    for (int k = 0; k < 6; k++) begin
      mem_req = (k <= 3);
      mem_addr = 64'h2000;
      mem_rd_ctrl = 3'b000;
      mem_wr_ctrl = 2'b11;
      mem_wdata = 64'hCAFE_F00D;
      settle();
      if (d_wr[1] != 2'b00) nwr++;
      if (k == 0)
        chk("store.dram_wdata", d_wd[1], 64'hCAFE_F00D);
      chk($sformatf("store.c%0d.mem_valid", k), 64'(memv[1]),
          64'(k == 3));
      chk($sformatf("store.c%0d.mem_rdata", k), memrd[1], keep);
      adv();
    end
    chk("store.wr_cycles", 64'(nwr), 64'd1);
    mem_wr_ctrl = 2'b00;

    // LAT=3 fetch flushed at cycle 1, then a fresh fetch
    idle(6);
    for (int k = 0; k < 9; k++) begin
      if_req = (k <= 7);
      if_flush = (k == 1);
      if_addr = (k < 2) ? 64'h8000_0100 : 64'h8000_0200;
      settle();
      chk($sformatf("flush.c%0d.if_valid", k), 64'(ifv[1]), 64'(k == 7));
      if (k >= 1 && k <= 3)
        chk($sformatf("flush.c%0d.held_addr", k), d_addr[1],
            64'h8000_0100);
      if (k == 4) begin
        chk("flush.regrant_addr", d_addr[1], 64'h8000_0200);
        chk("flush.regrant_rd", 64'(d_rd[1]), 64'(3'b101));
      end
      if (k == 7)
        chk("flush.new_rdata", ifrd[1], dram_rdata);
      adv();
    end

    // reset in the middle of a LAT=3 MEM access
    idle(4);
    mem_req = 1'b1;
    mem_rd_ctrl = 3'b010;
    mem_addr = 64'h3000;
    settle();
    chk("abort.issue_rd", 64'(d_rd[1]), 64'(3'b010));
    adv();
    mem_req = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("abort.dram_rd", 64'(d_rd[1]), 64'd0);
    chk("abort.dram_addr", d_addr[1], 64'd0);
    chk("abort.dram_wr", 64'(d_wr[1]), 64'd0);
    chk("abort.dram_wdata", d_wd[1], 64'd0);
    chk("abort.mem_valid", 64'(memv[1]), 64'd0);
    chk("abort.mem_rdata", memrd[1], 64'd0);
    chk("abort.if_rdata", ifrd[1], 64'd0);
    settle();
    adv();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk($sformatf("abort.c%0d.no_valid", k), 64'(memv[1]), 64'd0);
      adv();
    end

    // tie after reset: MEM first, IF right after mem_valid (LAT=1)
    if_req = 1'b1;
    mem_req = 1'b1;
    mem_rd_ctrl = 3'b100;
    mem_addr = 64'h4000;
    if_addr = 64'h8000_0040;
    settle();
    chk("tie.first_rd", 64'(d_rd[0]), 64'(3'b100));
    chk("tie.first_addr", d_addr[0], 64'h4000);
    adv();
    settle();
    chk("tie.mem_valid", 64'(memv[0]), 64'd1);
    adv();
    mem_req = 1'b0;
    settle();
    chk("tie.if_grant", 64'(d_rd[0]), 64'(3'b101));
    adv();
    settle();
    chk("tie.if_valid", 64'(ifv[0]), 64'd1);
    adv();
    idle(4);

    // random traffic against the model
    for (int k = 0; k < 600; k++) begin
      if_req = ($urandom_range(0, 3) != 0);
      if_flush = ($urandom_range(0, 7) == 0);
      mem_req = ($urandom_range(0, 1) == 1);
      mem_rd_ctrl = 3'($urandom_range(0, 7));
      mem_wr_ctrl = 2'($urandom_range(0, 3));
      if_addr = {$urandom, $urandom};
      mem_addr = {$urandom, $urandom};
      mem_wdata = {$urandom, $urandom};
      settle();
      adv();
    end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
